display_de_sete_segmentos_decodificador: RTL and testbench

Converts a 7-bit unsigned card-sum value into two registered 7-segment digit patterns: units and tens.
The blackjack top level instantiates it twice:
- player sum drives PrimeiroDigito/SegundoDigito;
- dealer sum drives QuartoDigito/TerceiroDigito.

---
 rtl/display_de_sete_segmentos_decodificador.sv | 73 +++++++
 tb/tb_display_de_sete_segmentos_decodificador.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/display_de_sete_segmentos_decodificador.sv
// Two-digit 7-segment decoder for a 0..127 card sum: units and tens patterns,
// registered, with blanking of the leading zero and a dash for values >= 100.
module display_de_sete_segmentos_decodificador #(
  parameter bit SEG_ATIVO_BAIXO = 1'b1,
  parameter bit APAGAR_ZERO_ESQ = 1'b1
) (
  input  logic       clock,
  input  logic       resetar,
  input  logic [6:0] data,
  output logic [6:0] PrimeiroDigito,
  output logic [6:0] SegundoDigito
);

  // Active-low reference patterns, bit order g,f,e,d,c,b,a.
  localparam logic [6:0] PAT_BLANK = 7'b1111111;
  localparam logic [6:0] PAT_DASH  = 7'b0111111;

  function automatic logic [6:0] digit_pattern(input logic [6:0] digit);
    case (digit)
      7'd0:    digit_pattern = 7'b1000000;
      7'd1:    digit_pattern = 7'b1111001;
      7'd2:    digit_pattern = 7'b0100100;
      7'd3:    digit_pattern = 7'b0110000;
      7'd4:    digit_pattern = 7'b0011001;
      7'd5:    digit_pattern = 7'b0010010;
      7'd6:    digit_pattern = 7'b0000010;
      7'd7:    digit_pattern = 7'b1111000;
      7'd8:    digit_pattern = 7'b0000000;
      7'd9:    digit_pattern = 7'b0010000;
      default: digit_pattern = PAT_DASH;
    endcase
  endfunction

  function automatic logic [6:0] apply_polarity(input logic [6:0] pat);
    apply_polarity = SEG_ATIVO_BAIXO ? pat : ~pat;
  endfunction

  logic [6:0] units_p0;
  logic [6:0] tens_p0;

  // Stage p0: combinational binary-to-digit decode of the current input.
  // Unknown input bits match no range item and fall through to the dash.
  always_comb begin
    units_p0 = PAT_DASH;
    tens_p0  = PAT_DASH;
    case (data) inside
      [7'd0:7'd9]: begin
        units_p0 = digit_pattern(data);
        tens_p0  = APAGAR_ZERO_ESQ ? PAT_BLANK : digit_pattern(7'd0);
      end
      [7'd10:7'd99]: begin
        units_p0 = digit_pattern(data % 7'd10);
        tens_p0  = digit_pattern(data / 7'd10);
      end
      default: begin
        units_p0 = PAT_DASH;
        tens_p0  = PAT_DASH;
      end
    endcase
  end

  // Stage p1: output registers; reset forces the blank pattern at once.
  always_ff @(posedge clock or negedge resetar) begin
    if (!resetar) begin
      PrimeiroDigito <= apply_polarity(PAT_BLANK);
      SegundoDigito  <= apply_polarity(PAT_BLANK);
    end else begin
      PrimeiroDigito <= apply_polarity(units_p0);
      SegundoDigito  <= apply_polarity(tens_p0);
    end
  end

endmodule

// File: tb/tb_display_de_sete_segmentos_decodificador.sv
// Self-checking bench for the two-digit 7-segment decoder (default parameters).
module tb_display_de_sete_segmentos_decodificador;

  logic       clock = 1'b0;
  logic       resetar = 1'b1;
  logic [6:0] data = 7'd25;
  logic [6:0] PrimeiroDigito;
  logic [6:0] SegundoDigito;

  int checks = 0;
  int failures = 0;

  display_de_sete_segmentos_decodificador #(
    .SEG_ATIVO_BAIXO(1'b1),
    .APAGAR_ZERO_ESQ(1'b1)
  ) dut (
    .clock(clock),
    .resetar(resetar),
    .data(data),
    .PrimeiroDigito(PrimeiroDigito),
    .SegundoDigito(SegundoDigito)
  );

  always #5 clock = ~clock;

  // Reference model: decimal digits by arithmetic, then a lookup of the
  // seven-segment drawing of each digit.
  logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic model(input int v, output logic [6:0] tens, output logic [6:0] units);
    if (v >= 100) begin
      tens  = 7'b0111111;
      units = 7'b0111111;
    end else begin
      units = seg_lut[v % 10];
      tens  = (v < 10) ? 7'b1111111 : seg_lut[v / 10];
    end
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present v at a falling edge, let one rising edge pass, check the pair.
  task automatic apply(input string tag, input int v, input logic [6:0] exp_tens,
                       input logic [6:0] exp_units);
    @(negedge clock);
    data = 7'(v);
    @(negedge clock);
    check({tag, "_tens"}, SegundoDigito, exp_tens);
    check({tag, "_units"}, PrimeiroDigito, exp_units);
  endtask

  logic [6:0] mt, mu;
  int last;

  initial begin
    // 1: asynchronous reset before any clock edge, then release
    #2 resetar = 1'b0;
    #1;
    check("rst_tens", SegundoDigito, 7'b1111111);
    check("rst_units", PrimeiroDigito, 7'b1111111);
    @(negedge clock);
    check("rst_hold_units", PrimeiroDigito, 7'b1111111);
    resetar = 1'b1;
    @(negedge clock);
    check("rel25_tens", SegundoDigito, 7'b0100100);
    check("rel25_units", PrimeiroDigito, 7'b0010010);

    // 2: single digits, leading zero blanked
    apply("d0", 0, 7'b1111111, 7'b1000000);
    apply("d7", 7, 7'b1111111, 7'b1111000);
    apply("d9", 9, 7'b1111111, 7'b0010000);

    // 3: two-digit values, including the 9->10 step
    apply("d10", 10, 7'b1111001, 7'b1000000);
    apply("d21", 21, 7'b0100100, 7'b1111001);
    apply("d31", 31, 7'b0110000, 7'b1111001);
    apply("d99", 99, 7'b0010000, 7'b0010000);

    // 4: overflow dash and recovery (99->100->127->99->17)
    apply("d100", 100, 7'b0111111, 7'b0111111);
    apply("d127", 127, 7'b0111111, 7'b0111111);
    apply("d99b", 99, 7'b0010000, 7'b0010000);
    apply("d17", 17, 7'b1111001, 7'b1111000);

    // 5: full sweep, pipelined so each check sees exactly one edge of latency
    @(negedge clock);
    data = 7'd0;
    last = 0;
    for (int v = 1; v <= 128; v++) begin
      @(negedge clock);
      model(last, mt, mu);
      check($sformatf("sweep%0d_tens", last), SegundoDigito, mt);
      check($sformatf("sweep%0d_units", last), PrimeiroDigito, mu);
      if (v == 19) begin
        // 6: reset pulse mid-sweep while data = 18
        data = 7'd18;
        #1 resetar = 1'b0;
        #1;
        check("midrst_tens", SegundoDigito, 7'b1111111);
        check("midrst_units", PrimeiroDigito, 7'b1111111);
        @(posedge clock);
        #1;
        check("midrst_hold", PrimeiroDigito, 7'b1111111);
        @(negedge clock);
        resetar = 1'b1;
        @(negedge clock);
        check("after_rst_tens", SegundoDigito, 7'b1111001);
        check("after_rst_units", PrimeiroDigito, 7'b0000000);
      end
      data = 7'(v % 128);
      last = v % 128;
    end

    // Random values, again with one-edge pipelined checking
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      model(last, mt, mu);
      check($sformatf("rnd%0d_tens", last), SegundoDigito, mt);
      check($sformatf("rnd%0d_units", last), PrimeiroDigito, mu);
      last = int'($urandom_range(0, 127));
      data = 7'(last);
    end
    @(negedge clock);
    model(last, mt, mu);
    check("rnd_last_tens", SegundoDigito, mt);
    check("rnd_last_units", PrimeiroDigito, mu);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
